irq_cp0_ctrl: RTL and testbench
===============================

Name: irq_cp0_ctrl

Overview:
Interrupt and coprocessor-0 controller that feeds the 5-stage pipeline's ID-stage PC-select and EX-stage mfc0/mtc0/eret datapath.
- Synchronises the three raw IO interrupt lines and latches rising edges as pending.
- Applies mask and global disable, then presents a prioritised redirect request with an entry vector to the pipeline.
- Holds the CP0 state: disable, mask, EPC and cause, exposed through a mfc0 read port and a mtc0 write port.

Parameters:
N_IRQ, 3, number of interrupt lines (fixed at 3 for this revision)
VEC2, 32'h0000_0400, entry address for line 2 (highest priority)
VEC1, 32'h0000_0600, entry address for line 1
VEC0, 32'h0000_0800, entry address for line 0 (lowest priority)

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-high
irq_in  in  3  raw interrupt levels from IO, asynchronous to clk
irq_req  out  1  redirect request to pipeline
irq_vector  out  32  entry address of the selected line; valid while irq_req=1
irq_id  out  2  index of the selected line; valid while irq_req=1
irq_ack  in  1  pipeline has taken the redirect this cycle
resume_pc  in  32  PC to save as EPC on ack
eret  in  1  exception-return instruction is retiring this cycle
epc  out  32  current EPC, for the eret PC mux
cp0_raddr  in  5  mfc0 register address
cp0_rdata  out  32  mfc0 read data, combinational
cp0_we  in  1  mtc0 write enable
cp0_waddr  in  5  mtc0 register address
cp0_wdata  in  32  mtc0 write data

Behaviour:
CP0 register map:
- 0x16: disable, bit0.
- 0x17: mask, bits[2:0]; 1 = enabled.
- 0x0e: EPC, 32 bits.
- 0x0d: cause = {26'b0, overflow[2:0], pending[2:0]}; read-only except W1C.
- Any other address reads 0; writes to it are ignored.

Reset:
- pending, overflow, mask, disable, EPC and all synchroniser flops are cleared to 0.
- Outputs after reset: irq_req=0, irq_id=0, irq_vector=VEC0, cp0_rdata=0 for every address.

Input path, per line:
- Two-flop synchroniser, then a previous-value flop; a rising edge is sync2 & ~prev.
- Edge-to-pending latency: irq_in sampled high at edge E0 gives pending=1 after edge E2.
- irq_req is high in the following cycle, provided the line is enabled and disable=0.
- An edge on a line whose pending bit is already set leaves pending at 1 and sets the sticky overflow bit.
- Level-held inputs generate only one edge.

Request:
- irq_req = |(pending & mask) & ~disable. It is driven from registers only, with no combinational path from any input.
- Priority is fixed: line 2 > line 1 > line 0.
- irq_id and irq_vector follow the highest enabled pending line.

Ack, on a clock edge where irq_ack=1 and irq_req=1:
- The selected pending bit is cleared.
- disable is set to 1.
- EPC is loaded with resume_pc.
- After the ack edge, irq_req=0 (because disable=1) until disable is cleared.
- irq_ack while irq_req=0 is ignored.

eret:
- disable is cleared to 0 on the edge.
- Another enabled pending line raises irq_req in the next cycle, so back-to-back service is possible.

mtc0:
- cp0_we writes 0x16, 0x17 or 0x0e.
- A write to 0x0d clears each pending/overflow bit whose corresponding wdata bit is 1: wdata[2:0] clears pending, wdata[5:3] clears overflow.

Simultaneous events, priority order:
- disable: ack > eret > mtc0.
- EPC: ack > mtc0.
- Pending bit: a new edge wins over an ack or W1C clear on the same line in the same cycle. The bit stays 1 and overflow is not set.
- mask write + ack in the same cycle: both apply. The cleared line is the one selected before the write.

Reset mid-operation: rst overrides every update in that cycle, including a simultaneous ack or edge.

Decomposition:
Shared package irq_cp0_pkg:
- CP0 address constants CP0_DISABLE=5'h16, CP0_MASK=5'h17, CP0_EPC=5'h0e, CP0_CAUSE=5'h0d.
- Default vector constants.
- N_IRQ.

One sub-module, irq_edge_sync:
- One line: 2-flop synchroniser plus edge detector, with clk and rst.
- Instantiated N_IRQ times.

Test Plan:
- Reset, then write mask=3'b111 and pulse irq_in[1] → irq_req=1, irq_id=1, irq_vector=32'h600 after the 3rd edge; ack with resume_pc=32'h0000_0124 → epc=32'h124, disable=1, irq_req=0, cause=0.
- irq_in[0] and irq_in[2] rise in the same cycle → irq_id=2, vector 32'h400; ack, then eret → next cycle irq_req=1, irq_id=0, vector 32'h800.
- mask=3'b000, pulse line 1 twice → irq_req stays 0, cp0_rdata@0x0d=32'h12; W1C write 32'h12 to 0x0d → reads 0.
- ack, eret and mtc0 0x16 wdata=0 in the same cycle → disable=1; ack with mtc0 0x0e=32'hdead_beef in the same cycle → epc=resume_pc.
- A new edge on line 1 arrives in the same cycle as the ack of line 1 → pending[1] stays 1, overflow[1]=0, irq_req reasserts after eret.
- Assert rst while pending and disable are both 1 and ack is high → all CP0 registers read 0 and irq_req=0 in the next cycle.

Source files
------------

// File: rtl/irq_cp0_pkg.sv
// Shared constants and helpers for the interrupt / coprocessor-0 controller.
package irq_cp0_pkg;

  localparam int unsigned N_IRQ = 3;

  localparam logic [4:0] CP0_DISABLE = 5'h16;
  localparam logic [4:0] CP0_MASK    = 5'h17;
  localparam logic [4:0] CP0_EPC     = 5'h0e;
  localparam logic [4:0] CP0_CAUSE   = 5'h0d;

  localparam logic [31:0] DEF_VEC2 = 32'h0000_0400;
  localparam logic [31:0] DEF_VEC1 = 32'h0000_0600;
  localparam logic [31:0] DEF_VEC0 = 32'h0000_0800;

  // Highest-numbered set line wins; returns 0 when nothing is set.
  function automatic logic [1:0] prio_sel(input logic [N_IRQ-1:0] lines);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (lines[i]) id = 2'(i);
    end
    return id;
  endfunction

  function automatic logic [N_IRQ-1:0] id_onehot(input logic [1:0] id);
    return N_IRQ'(1) << id;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One interrupt line: two-flop synchroniser followed by a rising-edge detector.
module irq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/irq_cp0_ctrl.sv
// Interrupt controller and CP0 register file: pending/overflow capture, masking,
// prioritised redirect request, EPC save on ack, and mfc0/mtc0 access.
module irq_cp0_ctrl
  import irq_cp0_pkg::*;
#(
  parameter logic [31:0] VEC2 = DEF_VEC2,
  parameter logic [31:0] VEC1 = DEF_VEC1,
  parameter logic [31:0] VEC0 = DEF_VEC0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq_req,
  output logic [31:0]      irq_vector,
  output logic [1:0]       irq_id,
  input  logic             irq_ack,
  input  logic [31:0]      resume_pc,
  input  logic             eret,
  output logic [31:0]      epc,
  input  logic [4:0]       cp0_raddr,
  output logic [31:0]      cp0_rdata,
  input  logic             cp0_we,
  input  logic [4:0]       cp0_waddr,
  input  logic [31:0]      cp0_wdata
);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] overflow_q, overflow_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic             disable_q, disable_d;
  logic [31:0]      epc_q, epc_d;

  logic [N_IRQ-1:0] enabled;
  logic [1:0]       sel_id;
  logic             ack_fire;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] w1c_pend, w1c_ovf;
  logic [N_IRQ-1:0] pend_clr;
  logic             wr_disable, wr_mask, wr_epc, wr_cause;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_edge_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (irq_in[i]),
      .rise (rise[i])
    );
  end

  // Request path depends only on registered state.
  always_comb begin
    enabled = pending_q & mask_q;
    irq_req = (|enabled) & ~disable_q;
    sel_id  = prio_sel(enabled);
    case (sel_id)
      2'd2:    irq_vector = VEC2;
      2'd1:    irq_vector = VEC1;
      default: irq_vector = VEC0;
    endcase
  end

  assign irq_id = sel_id;
  assign epc    = epc_q;

  always_comb begin
    wr_disable = cp0_we && (cp0_waddr == CP0_DISABLE);
    wr_mask    = cp0_we && (cp0_waddr == CP0_MASK);
    wr_epc     = cp0_we && (cp0_waddr == CP0_EPC);
    wr_cause   = cp0_we && (cp0_waddr == CP0_CAUSE);

    ack_fire = irq_ack & irq_req;
    ack_clr  = ack_fire ? id_onehot(sel_id) : '0;
    w1c_pend = wr_cause ? cp0_wdata[N_IRQ-1:0] : '0;
    w1c_ovf  = wr_cause ? cp0_wdata[2*N_IRQ-1:N_IRQ] : '0;
    pend_clr = ack_clr | w1c_pend;
  end

  always_comb begin
    // A fresh edge beats a same-cycle clear and then does not count as overflow.
    pending_d  = rise | (pending_q & ~pend_clr);
    overflow_d = (overflow_q & ~w1c_ovf) | (rise & pending_q & ~pend_clr);

    mask_d = wr_mask ? cp0_wdata[N_IRQ-1:0] : mask_q;

    if (ack_fire) begin
      disable_d = 1'b1;
    end else if (eret) begin
      disable_d = 1'b0;
    end else if (wr_disable) begin
      disable_d = cp0_wdata[0];
    end else begin
      disable_d = disable_q;
    end

    if (ack_fire) begin
      epc_d = resume_pc;
    end else if (wr_epc) begin
      epc_d = cp0_wdata;
    end else begin
      epc_d = epc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= '0;
      mask_q     <= '0;
      disable_q  <= 1'b0;
      epc_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      mask_q     <= mask_d;
      disable_q  <= disable_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    case (cp0_raddr)
      CP0_DISABLE: cp0_rdata = {31'b0, disable_q};
      CP0_MASK:    cp0_rdata = {{(32 - N_IRQ){1'b0}}, mask_q};
      CP0_EPC:     cp0_rdata = epc_q;
      CP0_CAUSE:   cp0_rdata = {{(32 - 2 * N_IRQ){1'b0}}, overflow_q, pending_q};
      default:     cp0_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_irq_cp0_ctrl.sv
// Directed bench for irq_cp0_ctrl with an expected-value scoreboard queue.
module tb_irq_cp0_ctrl;
  import irq_cp0_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq_in = '0;
  logic        irq_req;
  logic [31:0] irq_vector;
  logic [1:0]  irq_id;
  logic        irq_ack = 1'b0;
  logic [31:0] resume_pc = '0;
  logic        eret = 1'b0;
  logic [31:0] epc;
  logic [4:0]  cp0_raddr = '0;
  logic [31:0] cp0_rdata;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_waddr = '0;
  logic [31:0] cp0_wdata = '0;

  irq_cp0_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .resume_pc  (resume_pc),
    .eret       (eret),
    .epc        (epc),
    .cp0_raddr  (cp0_raddr),
    .cp0_rdata  (cp0_rdata),
    .cp0_we     (cp0_we),
    .cp0_waddr  (cp0_waddr),
    .cp0_wdata  (cp0_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_run++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, required an expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd(input logic [4:0] a);
    cp0_raddr = a;
    #1;
    check(cp0_rdata);
  endtask

  task automatic check_req_id_vec();
    check({31'b0, irq_req});
    check({30'b0, irq_id});
    check(irq_vector);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we    = 1'b1;
    cp0_waddr = a;
    cp0_wdata = d;
    tick();
    cp0_we    = 1'b0;
  endtask

  // Input high for one sampling edge, then two more edges until pending is set.
  task automatic pulse(input logic [2:0] lines);
    irq_in = lines;
    tick();
    irq_in = '0;
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    push("rst_req", 32'd0); push("rst_id", 32'd0); push("rst_vec", 32'h800);
    push("rst_disable", 32'd0); push("rst_mask", 32'd0); push("rst_epc", 32'd0);
    push("rst_cause", 32'd0);
    check_req_id_vec();
    check_rd(CP0_DISABLE); check_rd(CP0_MASK); check_rd(CP0_EPC); check_rd(CP0_CAUSE);

    // Line 1 latency and ack
    mtc0(CP0_MASK, 32'h7);
    push("mask_rd", 32'h7);
    check_rd(CP0_MASK);
    irq_in[1] = 1'b1;
    tick();
    irq_in[1] = 1'b0;
    tick();
    push("l1_req_early", 32'd0);
    check({31'b0, irq_req});
    tick();
    push("l1_req", 32'd1); push("l1_id", 32'd1); push("l1_vec", 32'h600);
    check_req_id_vec();
    irq_ack   = 1'b1;
    resume_pc = 32'h0000_0124;
    push("ack1_epc", 32'h124); push("ack1_disable", 32'd1);
    push("ack1_req", 32'd0); push("ack1_cause", 32'd0);
    tick();
    irq_ack = 1'b0;
    check(epc);
    check_rd(CP0_DISABLE);
    check({31'b0, irq_req});
    check_rd(CP0_CAUSE);

    // Simultaneous lines 0 and 2, priority and back-to-back service
    pulse(3'b101);
    push("dis_req", 32'd0); push("p02_cause", 32'h5);
    check({31'b0, irq_req});
    check_rd(CP0_CAUSE);
    eret = 1'b1;
    push("p2_req", 32'd1); push("p2_id", 32'd2); push("p2_vec", 32'h400);
    tick();
    eret = 1'b0;
    check_req_id_vec();
    irq_ack   = 1'b1;
    resume_pc = 32'h0000_0200;
    push("ack2_req", 32'd0); push("ack2_epc", 32'h200);
    tick();
    irq_ack = 1'b0;
    check({31'b0, irq_req});
    check(epc);
    eret = 1'b1;
    push("p0_req", 32'd1); push("p0_id", 32'd0); push("p0_vec", 32'h800);
    tick();
    eret = 1'b0;
    check_req_id_vec();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    eret    = 1'b1;
    push("idle_req", 32'd0); push("idle_cause", 32'd0); push("idle_disable", 32'd0);
    tick();
    eret = 1'b0;
    check({31'b0, irq_req});
    check_rd(CP0_CAUSE);
    check_rd(CP0_DISABLE);

    // Masked line, overflow, W1C
    mtc0(CP0_MASK, 32'h0);
    pulse(3'b010);
    pulse(3'b010);
    push("masked_req", 32'd0); push("ovf_cause", 32'h12);
    check({31'b0, irq_req});
    check_rd(CP0_CAUSE);
    mtc0(CP0_CAUSE, 32'h12);
    push("w1c_cause", 32'd0);
    check_rd(CP0_CAUSE);

    // Priority of simultaneous ack / eret / mtc0
    mtc0(CP0_MASK, 32'h7);
    pulse(3'b001);
    push("p0b_req", 32'd1);
    check({31'b0, irq_req});
    irq_ack   = 1'b1;
    eret      = 1'b1;
    resume_pc = 32'h0000_0300;
    cp0_we    = 1'b1;
    cp0_waddr = CP0_DISABLE;
    cp0_wdata = 32'h0;
    push("race_disable", 32'd1); push("race_epc", 32'h300); push("race_req", 32'd0);
    tick();
    irq_ack = 1'b0;
    eret    = 1'b0;
    cp0_we  = 1'b0;
    check_rd(CP0_DISABLE);
    check(epc);
    check({31'b0, irq_req});
    pulse(3'b100);
    mtc0(CP0_DISABLE, 32'h0);
    push("p2b_req", 32'd1); push("p2b_id", 32'd2); push("p2b_vec", 32'h400);
    check_req_id_vec();
    irq_ack   = 1'b1;
    resume_pc = 32'h0000_0444;
    cp0_we    = 1'b1;
    cp0_waddr = CP0_EPC;
    cp0_wdata = 32'hdead_beef;
    push("epc_race", 32'h444); push("epc_race_cause", 32'd0);
    tick();
    irq_ack = 1'b0;
    cp0_we  = 1'b0;
    check_rd(CP0_EPC);
    check_rd(CP0_CAUSE);

    // New edge coincident with ack on the same line
    pulse(3'b010);
    eret = 1'b1;
    push("l1b_req", 32'd1); push("l1b_id", 32'd1); push("l1b_vec", 32'h600);
    tick();
    eret = 1'b0;
    check_req_id_vec();
    irq_in[1] = 1'b1;
    tick();
    irq_in[1] = 1'b0;
    tick();
    irq_ack   = 1'b1;
    resume_pc = 32'h0000_0555;
    push("edge_ack_cause", 32'h2); push("edge_ack_req", 32'd0); push("edge_ack_epc", 32'h555);
    tick();
    irq_ack = 1'b0;
    check_rd(CP0_CAUSE);
    check({31'b0, irq_req});
    check(epc);
    eret = 1'b1;
    push("reassert_req", 32'd1); push("reassert_id", 32'd1); push("reassert_vec", 32'h600);
    tick();
    eret = 1'b0;
    check_req_id_vec();

    // Reset mid-operation with ack high
    mtc0(CP0_DISABLE, 32'h1);
    push("pre_rst_cause", 32'h2); push("pre_rst_disable", 32'd1);
    check_rd(CP0_CAUSE);
    check_rd(CP0_DISABLE);
    rst     = 1'b1;
    irq_ack = 1'b1;
    push("mrst_req", 32'd0); push("mrst_id", 32'd0); push("mrst_vec", 32'h800);
    push("mrst_disable", 32'd0); push("mrst_mask", 32'd0); push("mrst_epc", 32'd0);
    push("mrst_cause", 32'd0);
    tick();
    rst     = 1'b0;
    irq_ack = 1'b0;
    check_req_id_vec();
    check_rd(CP0_DISABLE); check_rd(CP0_MASK); check_rd(CP0_EPC); check_rd(CP0_CAUSE);

    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d pending, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
